data_in_loader: RTL and testbench
=================================

// Module: data_in_loader
// PURPOSE
// - Bit-serial packet receiver that sits directly upstream of the data_in_reg
//   configuration register bank.
// - Assembles bits MSB-first into bytes and decodes a header byte.
// - Emits one data_in_enable strobe per payload byte, with matching data_in,
//   byte_sel and in_sel, so the downstream bank loads trunc/priv/word-select fields.
// PARAMETERS
// - TIMEOUT_CYCLES  1000  idle clocks allowed between bits inside a packet before abort
// - TO_W            10    width of the timeout counter; must hold TIMEOUT_CYCLES
// PORTS
// - clk             in   1   system clock
// - rst_n           in   1   synchronous reset, active-low
// - ser_valid       in   1   ser_bit is sampled on this clk edge
// - ser_bit         in   1   serial data bit, MSB of each byte first
// - data_in_enable  out  1   one-cycle write strobe to downstream register bank
// - data_in         out  8   payload byte
// - byte_sel        out  2   payload byte index within packet (0..3)
// - in_sel          out  2   target field: 00 trunc, 01 trunc_sel, 10 priv, 11 word_sel
// - busy            out  1   packet in progress (any state other than IDLE)
// - pkt_done        out  1   one-cycle pulse, coincident with the last data_in_enable
// - err             out  1   one-cycle pulse on header reject, timeout or checksum fail
// BEHAVIOUR
// - Reset (rst_n=0 at clk edge): all outputs 0; bit count, byte count and timeout
//   counter 0; shift register 0; FSM = IDLE. Reset mid-packet discards the partial byte/packet.
// - Byte assembler: on each ser_valid, shift = {shift[6:0],ser_bit} and bitcnt+1.
//   The byte is complete on the 8th bit. It runs in every state except reset.
// - Header byte: [7:6]=in_sel, [5:4]=len-1 (payload bytes N=1..4), [3:0] must be 0.
// - Header is legal iff [3:0]==0 and N is within the field limit:
//   in_sel 00 -> N<=4, 01 -> N==1, 10/11 -> N<=2.
// - Illegal header: err pulses the cycle after the 8th bit; FSM stays IDLE; the next
//   byte is treated as a header.
// - FSM states:
//   - IDLE: wait for a header byte; legal header -> PAYLOAD with bytecnt=0.
//   - PAYLOAD: each completed byte gets index bytecnt, then bytecnt+1.
//     After byte N-1 -> IDLE (or CSUM when the checksum option is built).
//   - CSUM / EMIT: present only with the checksum option (see CONFIGURATION).
// - Emission latency (option off): data_in_enable=1 exactly 1 clk after the clk
//   sampling the 8th bit. data_in=byte, byte_sel=bytecnt, in_sel latched from header.
// - data_in, byte_sel and in_sel hold their values until the next strobe.
// - Timeout counter: cleared on every ser_valid and in IDLE with bitcnt==0; else +1.
//   Reaching TIMEOUT_CYCLES: err pulse, bitcnt/bytecnt=0, FSM -> IDLE, no strobe.
// - Partial bytes in IDLE are covered by the same timeout rule.
// - Simultaneous events:
//   - Byte completion and timeout in the same cycle: completion wins, counter clears.
//   - ser_valid on the emission cycle is accepted normally.
// CONFIGURATION
// - LOADER_CSUM_EN defined:
//   - After N payload bytes, one checksum byte follows: XOR of header and all
//     payload bytes.
//   - Payload bytes are buffered (4x8) and not emitted during PAYLOAD.
//   - Match: EMIT issues N strobes on N consecutive clks starting 1 clk after the
//     checksum byte completes, byte_sel 0..N-1; pkt_done on the last strobe.
//   - Mismatch: err pulse, nothing emitted, FSM -> IDLE.
// - LOADER_CSUM_EN undefined: no CSUM/EMIT states and no buffer; bytes stream out
//   as they complete.
// TESTING
// - Header 0x30 then bytes 0xAA,0xBB,0xCC,0xDD -> 4 strobes, in_sel=00, byte_sel 0..3,
//   data AA..DD; pkt_done on the 4th strobe.
// - Header 0x50 (in_sel 01, N=2) -> err pulse, no strobe; next header 0x40,0x2A
//   -> single strobe in_sel=01, data 0x2A.
// - Header 0x90, byte 0x12, then 1000 idle clks -> one strobe for 0x12, err at
//   timeout, busy=0; next byte is parsed as a header.
// - rst_n=0 after 5 bits of a payload byte -> all outputs 0; a fresh packet
//   0xD0,0x03,0x01 loads cleanly.
// - LOADER_CSUM_EN: 0x10,0x11,0x22,csum 0x23 -> 2 back-to-back strobes;
//   same packet with csum 0x24 -> err only.
// - Bits arriving every clk (max rate) for 0xC0,0xFF -> strobe exactly 1 clk
//   after the 16th bit.

Source files
------------

// File: rtl/data_in_loader.sv
// Bit-serial packet receiver feeding the data_in_reg configuration bank.
// Optional checksum/buffered emission is built when LOADER_CSUM_EN is defined.
//
// state   | meaning
// IDLE    | waiting for a header byte
// PAYLOAD | receiving payload bytes (streamed out, or buffered with checksum)
// CSUM    | waiting for the checksum byte (LOADER_CSUM_EN only)
// EMIT    | replaying buffered bytes one per clk (LOADER_CSUM_EN only)
module data_in_loader #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int TO_W           = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ser_valid,
  input  logic       ser_bit,
  output logic       data_in_enable,
  output logic [7:0] data_in,
  output logic [1:0] byte_sel,
  output logic [1:0] in_sel,
  output logic       busy,
  output logic       pkt_done,
  output logic       err
);

`ifdef LOADER_CSUM_EN
  typedef enum logic [1:0] {IDLE, PAYLOAD, CSUM, EMIT} state_t;
`else
  typedef enum logic [0:0] {IDLE, PAYLOAD} state_t;
`endif

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_t          state_q, state_d;
  logic [6:0]      shift_q, shift_d;
  logic [2:0]      bitcnt_q, bitcnt_d;
  logic [1:0]      bytecnt_q, bytecnt_d;
  logic [1:0]      len_q, len_d;
  logic [1:0]      sel_q, sel_d;
  logic [TO_W-1:0] to_q, to_d;
  logic            en_q, en_d;
  logic [7:0]      data_q, data_d;
  logic [1:0]      bsel_q, bsel_d;
  logic [1:0]      isel_q, isel_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
`ifdef LOADER_CSUM_EN
  logic [7:0]      csum_q, csum_d;
  logic [7:0]      buf_q [4];
  logic [7:0]      buf_d [4];
`endif

  logic       byte_done;
  logic [7:0] byte_val;
  logic       timeout;

  assign byte_done = ser_valid && (bitcnt_q == 3'd7);
  assign byte_val  = {shift_q, ser_bit};

  // Low nibble must be zero; payload length is capped per target field.
  function automatic logic hdr_legal(input logic [7:0] h);
    if (h[3:0] != 4'd0) return 1'b0;
    case (h[7:6])
      2'b00:   return 1'b1;
      2'b01:   return (h[5:4] == 2'd0);
      default: return (h[5] == 1'b0);
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    shift_d   = ser_valid ? byte_val[6:0] : shift_q;
    bitcnt_d  = ser_valid ? bitcnt_q + 3'd1 : bitcnt_q;
    bytecnt_d = bytecnt_q;
    len_d     = len_q;
    sel_d     = sel_q;
    to_d      = to_q;
    en_d      = 1'b0;
    data_d    = data_q;
    bsel_d    = bsel_q;
    isel_d    = isel_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    timeout   = 1'b0;
`ifdef LOADER_CSUM_EN
    csum_d    = csum_q;
    buf_d     = buf_q;
`endif

    if (ser_valid || (state_q == IDLE && bitcnt_q == 3'd0)) begin
      to_d = '0;
    end else if (to_q == TO_LAST) begin
      to_d    = '0;
      timeout = 1'b1;
    end else begin
      to_d = to_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (byte_done) begin
          if (hdr_legal(byte_val)) begin
            state_d   = PAYLOAD;
            bytecnt_d = 2'd0;
            len_d     = byte_val[5:4];
            sel_d     = byte_val[7:6];
`ifdef LOADER_CSUM_EN
            csum_d    = byte_val;
`endif
          end else begin
            err_d = 1'b1;
          end
        end
      end

      PAYLOAD: begin
        if (byte_done) begin
`ifdef LOADER_CSUM_EN
          buf_d[bytecnt_q] = byte_val;
          csum_d           = csum_q ^ byte_val;
          if (bytecnt_q == len_q) begin
            state_d   = CSUM;
            bytecnt_d = 2'd0;
          end else begin
            bytecnt_d = bytecnt_q + 2'd1;
          end
`else
          en_d   = 1'b1;
          data_d = byte_val;
          bsel_d = bytecnt_q;
          isel_d = sel_q;
          if (bytecnt_q == len_q) begin
            done_d    = 1'b1;
            state_d   = IDLE;
            bytecnt_d = 2'd0;
          end else begin
            bytecnt_d = bytecnt_q + 2'd1;
          end
`endif
        end
      end

`ifdef LOADER_CSUM_EN
      // The first strobe is issued from CSUM so that emission starts one clk
      // after the checksum byte, matching the streaming latency.
      CSUM: begin
        if (byte_done) begin
          if (byte_val == csum_q) begin
            en_d   = 1'b1;
            data_d = buf_q[0];
            bsel_d = 2'd0;
            isel_d = sel_q;
            if (len_q == 2'd0) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              state_d   = EMIT;
              bytecnt_d = 2'd1;
            end
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end

      EMIT: begin
        en_d   = 1'b1;
        data_d = buf_q[bytecnt_q];
        bsel_d = bytecnt_q;
        isel_d = sel_q;
        if (bytecnt_q == len_q) begin
          done_d    = 1'b1;
          state_d   = IDLE;
          bytecnt_d = 2'd0;
        end else begin
          bytecnt_d = bytecnt_q + 2'd1;
        end
      end
`endif

      default: state_d = IDLE;
    endcase

    // Timeout cannot coincide with byte completion: ser_valid clears the counter.
    if (timeout) begin
      err_d     = 1'b1;
      bitcnt_d  = 3'd0;
      bytecnt_d = 2'd0;
      state_d   = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bitcnt_q  <= '0;
      bytecnt_q <= '0;
      len_q     <= '0;
      sel_q     <= '0;
      to_q      <= '0;
      en_q      <= 1'b0;
      data_q    <= '0;
      bsel_q    <= '0;
      isel_q    <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef LOADER_CSUM_EN
      csum_q    <= '0;
      for (int i = 0; i < 4; i++) buf_q[i] <= '0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bitcnt_q  <= bitcnt_d;
      bytecnt_q <= bytecnt_d;
      len_q     <= len_d;
      sel_q     <= sel_d;
      to_q      <= to_d;
      en_q      <= en_d;
      data_q    <= data_d;
      bsel_q    <= bsel_d;
      isel_q    <= isel_d;
      done_q    <= done_d;
      err_q     <= err_d;
`ifdef LOADER_CSUM_EN
      csum_q    <= csum_d;
      for (int i = 0; i < 4; i++) buf_q[i] <= buf_d[i];
`endif
    end
  end

  assign data_in_enable = en_q;
  assign data_in        = data_q;
  assign byte_sel       = bsel_q;
  assign in_sel         = isel_q;
  assign pkt_done       = done_q;
  assign err            = err_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_data_in_loader.sv
// Directed bench for data_in_loader: strobe timing/content, header rejection,
// timeout, mid-packet reset and (when built) checksum handling.
module tb_data_in_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ser_valid = 1'b0;
  logic       ser_bit = 1'b0;
  logic       data_in_enable;
  logic [7:0] data_in;
  logic [1:0] byte_sel;
  logic [1:0] in_sel;
  logic       busy;
  logic       pkt_done;
  logic       err;

  data_in_loader dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ser_valid      (ser_valid),
    .ser_bit        (ser_bit),
    .data_in_enable (data_in_enable),
    .data_in        (data_in),
    .byte_sel       (byte_sel),
    .in_sel         (in_sel),
    .busy           (busy),
    .pkt_done       (pkt_done),
    .err            (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         c;
    logic [7:0] d;
    logic [1:0] bs;
    logic [1:0] is;
    logic       pd;
  } stb_t;

  stb_t sq[$];
  int   eq[$];

  // Record strobes and error pulses with the posedge count they follow.
  always @(negedge clk) begin
    if (data_in_enable === 1'b1) sq.push_back('{cyc, data_in, byte_sel, in_sel, pkt_done});
    if (err === 1'b1) eq.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_stb(input string tag, input int idx, input int ecyc, input logic [7:0] d,
                         input logic [1:0] bs, input logic [1:0] is, input logic pd);
    if (idx < sq.size()) begin
      chk({tag, "_cyc"}, sq[idx].c, ecyc);
      chk({tag, "_val"}, 32'({sq[idx].d, sq[idx].bs, sq[idx].is, sq[idx].pd}), 32'({d, bs, is, pd}));
    end else begin
      n_cmp++;
      n_bad++;
      $error("FAIL %s: strobe %0d observed missing expected present", tag, idx);
    end
  endtask

  task automatic chk_err_at(input string tag, input int ecyc);
    if (eq.size() > 0) begin
      chk(tag, eq[0], ecyc);
    end else begin
      n_cmp++;
      n_bad++;
      $error("FAIL %s: err pulse observed none expected at %0d", tag, ecyc);
    end
  endtask

  task automatic send_bits(input logic [7:0] b, input int n, output int lc);
    for (int i = 7; i > 7 - n; i--) begin
      @(negedge clk);
      ser_valid = 1'b1;
      ser_bit   = b[i];
    end
    lc = cyc;
  endtask

  task automatic send_byte(input logic [7:0] b, output int lc);
    send_bits(b, 8, lc);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      ser_valid = 1'b0;
    end
    #1;
  endtask

  task automatic clear_q();
    sq.delete();
    eq.delete();
  endtask

  int l0, l1, l2, l3, lx;

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs", 32'({data_in_enable, data_in, byte_sel, in_sel, busy, pkt_done, err}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    clear_q();

`ifdef LOADER_CSUM_EN
    // 0x10 ^ 0x11 ^ 0x22 = 0x23
    send_byte(8'h10, lx); send_byte(8'h11, l0); send_byte(8'h22, l1); send_byte(8'h23, l2);
    idle(4);
    chk("csum_ok_count", sq.size(), 2);
    chk_stb("csum_ok_s0", 0, l2 + 1, 8'h11, 2'd0, 2'd0, 1'b0);
    chk_stb("csum_ok_s1", 1, l2 + 2, 8'h22, 2'd1, 2'd0, 1'b1);
    chk("csum_ok_err", eq.size(), 0);
    chk("csum_ok_busy", busy, 0);

    clear_q();
    send_byte(8'h10, lx); send_byte(8'h11, l0); send_byte(8'h22, l1); send_byte(8'h24, l2);
    idle(4);
    chk("csum_bad_count", sq.size(), 0);
    chk("csum_bad_nerr", eq.size(), 1);
    chk_err_at("csum_bad_err", l2 + 1);
    chk("csum_bad_busy", busy, 0);

    // 0x40 ^ 0x5A = 0x1A
    clear_q();
    send_byte(8'h40, lx); send_byte(8'h5A, l0); send_byte(8'h1A, l1);
    idle(3);
    chk("csum_one_count", sq.size(), 1);
    chk_stb("csum_one_s0", 0, l1 + 1, 8'h5A, 2'd0, 2'd1, 1'b1);

    clear_q();
    send_byte(8'h50, l0);
    idle(3);
    chk("csum_hdr_rej", eq.size(), 1);
    chk_err_at("csum_hdr_rej_t", l0 + 1);
    chk("csum_hdr_rej_busy", busy, 0);
`else
    send_byte(8'h30, lx);
    send_byte(8'hAA, l0); send_byte(8'hBB, l1); send_byte(8'hCC, l2); send_byte(8'hDD, l3);
    idle(3);
    chk("pkt4_count", sq.size(), 4);
    chk_stb("pkt4_s0", 0, l0 + 1, 8'hAA, 2'd0, 2'd0, 1'b0);
    chk_stb("pkt4_s1", 1, l1 + 1, 8'hBB, 2'd1, 2'd0, 1'b0);
    chk_stb("pkt4_s2", 2, l2 + 1, 8'hCC, 2'd2, 2'd0, 1'b0);
    chk_stb("pkt4_s3", 3, l3 + 1, 8'hDD, 2'd3, 2'd0, 1'b1);
    chk("pkt4_err", eq.size(), 0);
    chk("pkt4_busy", busy, 0);
    chk("pkt4_hold", 32'({data_in, byte_sel}), 32'({8'hDD, 2'd3}));

    clear_q();
    send_byte(8'h50, l0);
    idle(3);
    chk("rej50_nerr", eq.size(), 1);
    chk_err_at("rej50_t", l0 + 1);
    chk("rej50_nstb", sq.size(), 0);
    chk("rej50_busy", busy, 0);
    clear_q();
    send_byte(8'h40, lx); send_byte(8'h2A, l0);
    idle(3);
    chk("hdr40_count", sq.size(), 1);
    chk_stb("hdr40_s0", 0, l0 + 1, 8'h2A, 2'd0, 2'd1, 1'b1);

    clear_q();
    send_byte(8'h01, lx); idle(2);
    send_byte(8'h70, lx); idle(2);
    send_byte(8'hA0, lx); idle(2);
    chk("rej_misc_nerr", eq.size(), 3);
    chk("rej_misc_nstb", sq.size(), 0);
    clear_q();
    send_byte(8'h00, lx); send_byte(8'h77, l0);
    idle(3);
    chk("hdr00_count", sq.size(), 1);
    chk_stb("hdr00_s0", 0, l0 + 1, 8'h77, 2'd0, 2'd0, 1'b1);

    clear_q();
    send_byte(8'h90, lx); send_byte(8'h12, l0);
    idle(999);
    chk("to_pre_busy", busy, 1);
    chk("to_pre_nerr", eq.size(), 0);
    idle(2);
    chk("to_nerr", eq.size(), 1);
    chk_err_at("to_err_t", l0 + 1001);
    chk("to_busy", busy, 0);
    chk("to_count", sq.size(), 1);
    chk_stb("to_s0", 0, l0 + 1, 8'h12, 2'd0, 2'd2, 1'b0);
    clear_q();
    send_byte(8'h40, lx); send_byte(8'h5C, l0);
    idle(3);
    chk("to_next_count", sq.size(), 1);
    chk_stb("to_next_s0", 0, l0 + 1, 8'h5C, 2'd0, 2'd1, 1'b1);

    clear_q();
    send_bits(8'hE0, 3, l0);
    idle(1003);
    chk("part_nerr", eq.size(), 1);
    chk_err_at("part_err_t", l0 + 1001);
    clear_q();
    send_byte(8'h00, lx); send_byte(8'h77, l0);
    idle(3);
    chk("part_next_count", sq.size(), 1);
    chk_stb("part_next_s0", 0, l0 + 1, 8'h77, 2'd0, 2'd0, 1'b1);

    clear_q();
    send_byte(8'hD0, lx); send_byte(8'h55, l0); send_bits(8'hFF, 5, l1);
    @(negedge clk);
    ser_valid = 1'b0;
    rst_n     = 1'b0;
    @(negedge clk);
    #1;
    chk("rstmid_pre_stb", sq.size(), 1);
    chk("rstmid_outputs", 32'({data_in_enable, data_in, byte_sel, in_sel, busy, pkt_done, err}), 32'd0);
    rst_n = 1'b1;
    idle(2);
    clear_q();
    send_byte(8'hD0, lx); send_byte(8'h03, l0); send_byte(8'h01, l1);
    idle(3);
    chk("rstmid_count", sq.size(), 2);
    chk_stb("rstmid_s0", 0, l0 + 1, 8'h03, 2'd0, 2'd3, 1'b0);
    chk_stb("rstmid_s1", 1, l1 + 1, 8'h01, 2'd1, 2'd3, 1'b1);
    chk("rstmid_err", eq.size(), 0);

    clear_q();
    send_byte(8'hC0, lx); send_byte(8'hFF, l0);
    idle(3);
    chk("maxrate_count", sq.size(), 1);
    chk_stb("maxrate_s0", 0, l0 + 1, 8'hFF, 2'd0, 2'd3, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
